// File: rtl/cnn_layer_accel_sys_rd_pkg.sv
// Shared types, widths and round-robin helpers for the FAS system-memory read arbiter.
package cnn_layer_accel_sys_rd_pkg;

  localparam int unsigned NUM_RD_ID = 4;
  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned LEN_W     = 16;
  localparam int unsigned DATA_W    = 512;
  localparam int unsigned ID_W      = $clog2(NUM_RD_ID);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2,
    ST_CMPL = 2'd3
  } state_t;

  // Latched burst command for the memory read channel.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
  } rd_cmd_t;

  // First requesting ID at or after ptr, wrapping; 0 when nothing requests.
  function automatic logic [ID_W-1:0] rr_select(input logic [NUM_RD_ID-1:0] req,
                                                input logic [ID_W-1:0]      ptr);
    logic [ID_W-1:0] sel;
    logic [ID_W-1:0] idx;
    logic            found;
    sel   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_RD_ID; k++) begin
      idx = ID_W'((32'(ptr) + k) % NUM_RD_ID);
      if (!found && req[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  // Next pointer value after granting id, wrapping at NUM_RD_ID.
  function automatic logic [ID_W-1:0] id_inc(input logic [ID_W-1:0] id);
    return (32'(id) == NUM_RD_ID - 1) ? '0 : id + ID_W'(1);
  endfunction

endpackage

// File: rtl/cnn_layer_accel_rr_arb.sv
// Round-robin priority picker with a registered rotating pointer.
module cnn_layer_accel_rr_arb
  import cnn_layer_accel_sys_rd_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_RD_ID-1:0] i_req,
  input  logic                 i_adv,
  output logic [ID_W-1:0]      o_gnt_id_c,
  output logic                 o_any_c
);

  logic [ID_W-1:0] r_ptr;

  assign o_gnt_id_c = rr_select(i_req, r_ptr);
  assign o_any_c    = |i_req;

  // Pointer moves just past the granted ID whenever a grant is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_adv) begin
      r_ptr <= id_inc(o_gnt_id_c);
    end
  end

endmodule

// File: rtl/cnn_layer_accel_sys_rd_arb.sv
// Arbitrates per-ID FAS read requests onto one memory read channel, one burst at a time.
module cnn_layer_accel_sys_rd_arb
  import cnn_layer_accel_sys_rd_pkg::*;
#(
  parameter int unsigned C_NUM_RD_ID = NUM_RD_ID,
  parameter int unsigned C_ADDR_WTH  = ADDR_W,
  parameter int unsigned C_LEN_WTH   = LEN_W,
  parameter int unsigned C_DATA_WTH  = DATA_W
) (
  input  logic                              clk_intf,
  input  logic                              rst_n,
  input  logic [C_NUM_RD_ID-1:0]            sys_mem_read_req,
  input  logic [C_NUM_RD_ID*C_ADDR_WTH-1:0] sys_mem_read_addr,
  input  logic [C_NUM_RD_ID*C_LEN_WTH-1:0]  sys_mem_read_len,
  output logic [C_NUM_RD_ID-1:0]            sys_mem_read_req_ack,
  output logic [C_NUM_RD_ID-1:0]            sys_mem_read_in_prog,
  output logic [C_DATA_WTH-1:0]             sys_mem_read_data,
  output logic                              sys_mem_read_data_vld,
  input  logic [C_NUM_RD_ID-1:0]            sys_mem_read_data_rdy,
  output logic [C_NUM_RD_ID-1:0]            sys_mem_read_cmpl,
  output logic                              mem_rd_cmd_vld,
  input  logic                              mem_rd_cmd_rdy,
  output logic [C_ADDR_WTH-1:0]             mem_rd_cmd_addr,
  output logic [C_LEN_WTH-1:0]              mem_rd_cmd_len,
  input  logic [C_DATA_WTH-1:0]             mem_rd_data,
  input  logic                              mem_rd_data_vld,
  output logic                              mem_rd_data_rdy
);

  state_t                 r_state, w_nxt_state;
  logic [ID_W-1:0]        w_gnt_id;
  logic [ID_W-1:0]        r_id;
  logic                   w_any;
  logic                   w_grant;
  logic                   w_in_data;
  logic                   w_cmd_fire;
  logic                   w_beat_fire;
  rd_cmd_t                r_cmd;
  logic [C_LEN_WTH-1:0]   r_beat_cnt;
  logic [C_NUM_RD_ID-1:0] r_ack;
  logic [C_NUM_RD_ID-1:0] r_in_prog;
  logic [C_NUM_RD_ID-1:0] r_cmpl;
  logic                   r_cmd_vld;
  logic [C_ADDR_WTH-1:0]  w_addr [C_NUM_RD_ID];
  logic [C_LEN_WTH-1:0]   w_len  [C_NUM_RD_ID];

  // Unpack the per-ID address/length slices.
  for (genvar g = 0; g < C_NUM_RD_ID; g++) begin : g_slice
    assign w_addr[g] = sys_mem_read_addr[g*C_ADDR_WTH +: C_ADDR_WTH];
    assign w_len[g]  = sys_mem_read_len[g*C_LEN_WTH +: C_LEN_WTH];
  end

  cnn_layer_accel_rr_arb u_rr_arb (
    .clk        (clk_intf),
    .rst_n      (rst_n),
    .i_req      (sys_mem_read_req),
    .i_adv      (w_grant),
    .o_gnt_id_c (w_gnt_id),
    .o_any_c    (w_any)
  );

  assign w_in_data   = (r_state == ST_DATA);
  assign w_cmd_fire  = r_cmd_vld & mem_rd_cmd_rdy;
  assign w_beat_fire = w_in_data & mem_rd_data_vld & sys_mem_read_data_rdy[r_id];

  // State register.
  always_ff @(posedge clk_intf or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nxt_state;
    end
  end

  // Next-state logic; a grant is only taken from IDLE.
  always_comb begin
    w_nxt_state = r_state;
    w_grant     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_grant     = 1'b1;
          w_nxt_state = (w_len[w_gnt_id] == '0) ? ST_CMPL : ST_CMD;
        end
      end
      ST_CMD:  if (w_cmd_fire) w_nxt_state = ST_DATA;
      ST_DATA: if (w_beat_fire && (r_beat_cnt == C_LEN_WTH'(1))) w_nxt_state = ST_CMPL;
      ST_CMPL: w_nxt_state = ST_IDLE;
      default: w_nxt_state = ST_IDLE;
    endcase
  end

  // Burst context, handshake pulses and beat counter.
  always_ff @(posedge clk_intf or negedge rst_n) begin
    if (!rst_n) begin
      r_id       <= '0;
      r_cmd      <= '0;
      r_beat_cnt <= '0;
      r_ack      <= '0;
      r_in_prog  <= '0;
      r_cmpl     <= '0;
      r_cmd_vld  <= 1'b0;
    end else begin
      r_ack  <= '0;
      r_cmpl <= '0;
      if (w_grant) begin
        r_ack[w_gnt_id]     <= 1'b1;
        r_in_prog[w_gnt_id] <= 1'b1;
        r_id                <= w_gnt_id;
        r_cmd               <= rd_cmd_t'{addr: w_addr[w_gnt_id], len: w_len[w_gnt_id]};
      end
      // Command goes out the cycle after the ack and holds until accepted.
      if ((r_state == ST_CMD) && !r_cmd_vld) begin
        r_cmd_vld <= 1'b1;
      end else if (w_cmd_fire) begin
        r_cmd_vld <= 1'b0;
      end
      if (w_cmd_fire) begin
        r_beat_cnt <= r_cmd.len;
      end else if (w_beat_fire) begin
        r_beat_cnt <= r_beat_cnt - C_LEN_WTH'(1);
      end
      if (r_state == ST_CMPL) begin
        r_cmpl[r_id] <= 1'b1;
        r_in_prog    <= '0;
      end
    end
  end

  assign sys_mem_read_req_ack  = r_ack;
  assign sys_mem_read_in_prog  = r_in_prog;
  assign sys_mem_read_cmpl     = r_cmpl;
  assign mem_rd_cmd_vld        = r_cmd_vld;
  assign mem_rd_cmd_addr       = r_cmd.addr;
  assign mem_rd_cmd_len        = r_cmd.len;
  assign sys_mem_read_data     = w_in_data ? mem_rd_data : '0;
  assign sys_mem_read_data_vld = w_in_data & mem_rd_data_vld;
  assign mem_rd_data_rdy       = w_in_data & sys_mem_read_data_rdy[r_id];

endmodule
